// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Memory handshake between the multicycle controller and the unified
//   instruction/data memory.
//   MemReq_o    : request valid (controller -> memory)
//   MemWrite_o  : request is a store (controller -> memory)
//   AddrSrc_o   : address select, 0=PC, 1=ALUOut (controller -> memory mux)
//   mem_ready_i : memory completes the current request this cycle
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic MemReq_o;
    logic MemWrite_o;
    logic AddrSrc_o;
    logic mem_ready_i;

    modport master (
        output MemReq_o,
        output MemWrite_o,
        output AddrSrc_o,
        input  mem_ready_i
    );

    modport slave (
        input  MemReq_o,
        input  MemWrite_o,
        input  AddrSrc_o,
        output mem_ready_i
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Sequencing FSM for a multicycle RISC-V subset (R-type, addi, lw, sw, beq)
//   sharing one ALU and one unified memory.
//   clk_i, rst_i (async active-low), start_i (run enable, sampled at
//   instruction boundaries), Op_i (opcode from IR), Zero_i (ALU zero flag),
//   mem (memory handshake interface, master side),
//   datapath controls IRWrite_o/PCWrite_o/ALUSrcA_o/ALUSrcB_o/ALUOp_o/
//   ResultSrc_o/RegWrite_o, status Busy_o/Trap_o/TrapCause_o and the
//   retired-instruction counter InstrCount_o.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [6:0]           Op_i,
    input  logic                 Zero_i,
    multicycle_control_if.master mem,
    output logic                 IRWrite_o,
    output logic                 PCWrite_o,
    output logic [1:0]           ALUSrcA_o,
    output logic [1:0]           ALUSrcB_o,
    output logic [1:0]           ALUOp_o,
    output logic [1:0]           ResultSrc_o,
    output logic                 RegWrite_o,
    output logic                 Busy_o,
    output logic                 Trap_o,
    output logic [1:0]           TrapCause_o,
    output logic [CNT_W-1:0]     InstrCount_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_ALUWB  = 3'd5,
        S_MEMWB  = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [2:0] CLS_R    = 3'b011;
    localparam logic [2:0] CLS_ADDI = 3'b001;
    localparam logic [2:0] CLS_LW   = 3'b000;
    localparam logic [2:0] CLS_SW   = 3'b010;
    localparam logic [2:0] CLS_BEQ  = 3'b110;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Wait counter only needs to reach TIMEOUT-1; the last not-ready cycle traps.
    localparam int                  WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [2:0]         cls_q, cls_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;

    logic               retire_s;
    logic               fault_s;
    logic [1:0]         fault_cause_s;
    logic               timeout_s;
    logic               mem_req_s, mem_write_s, addr_src_s;
    logic               ir_write_s, pc_write_s, reg_write_s;
    logic [1:0]         alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;

    // Only the class bits of the opcode steer sequencing.
    logic               op_unused_s;
    assign op_unused_s = ^Op_i[3:0];

    // A ready in the final allowed wait cycle wins over the timeout.
    assign timeout_s = (TIMEOUT != 0) && !mem.mem_ready_i && (wait_q == WAIT_LAST);

    // Next-state, counters and per-state control outputs.
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        wait_d        = {WAIT_W{1'b0}};
        cnt_d         = cnt_q;
        trap_d        = trap_q;
        cause_d       = cause_q;
        retire_s      = 1'b0;
        fault_s       = 1'b0;
        fault_cause_s = CAUSE_NONE;
        mem_req_s     = 1'b0;
        mem_write_s   = 1'b0;
        addr_src_s    = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_op_s      = 2'b00;
        result_src_s  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b10;
                if (mem.mem_ready_i) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_s) begin
                    fault_s       = 1'b1;
                    fault_cause_s = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DECODE: begin
                // Branch target = oldPC + offset lands in ALUOut for beq.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b11;
                cls_d       = Op_i[6:4];
                case (Op_i[6:4])
                    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ: state_d = S_EXEC;
                    default: begin
                        fault_s       = 1'b1;
                        fault_cause_s = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a_s = 2'b10;
                case (cls_q)
                    CLS_R: begin
                        alu_op_s = 2'b10;
                        state_d  = S_ALUWB;
                    end
                    CLS_ADDI: begin
                        alu_src_b_s = 2'b01;
                        state_d     = S_ALUWB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src_b_s = 2'b01;
                        state_d     = S_MEM;
                    end
                    CLS_BEQ: begin
                        // PC loads the branch target held in ALUOut when taken.
                        alu_op_s   = 2'b01;
                        pc_write_s = Zero_i;
                        retire_s   = 1'b1;
                    end
                    default: begin
                        fault_s       = 1'b1;
                        fault_cause_s = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                mem_req_s   = 1'b1;
                addr_src_s  = 1'b1;
                mem_write_s = (cls_q == CLS_SW);
                if (mem.mem_ready_i) begin
                    if (cls_q == CLS_LW) begin
                        state_d = S_MEMWB;
                    end else begin
                        retire_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    fault_s       = 1'b1;
                    fault_cause_s = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                result_src_s = 2'b01;
                retire_s     = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Faulting instruction is never counted; first cause is kept.
        if (fault_s) begin
            state_d = S_TRAP;
            if (!trap_q) begin
                trap_d  = 1'b1;
                cause_d = fault_cause_s;
            end else begin
                cause_d = cause_q;
            end
        end else if (retire_s) begin
            cnt_d = cnt_q + CNT_ONE;
            if (start_i) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, class, wait counter, retire counter and sticky trap registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cls_q   <= 3'b000;
            wait_q  <= {WAIT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign mem.MemReq_o   = mem_req_s;
    assign mem.MemWrite_o = mem_write_s;
    assign mem.AddrSrc_o  = addr_src_s;
    assign IRWrite_o      = ir_write_s;
    assign PCWrite_o      = pc_write_s;
    assign ALUSrcA_o      = alu_src_a_s;
    assign ALUSrcB_o      = alu_src_b_s;
    assign ALUOp_o        = alu_op_s;
    assign ResultSrc_o    = result_src_s;
    assign RegWrite_o     = reg_write_s;
    assign Busy_o         = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign Trap_o         = trap_q;
    assign TrapCause_o    = cause_q;
    assign InstrCount_o   = cnt_q;

endmodule
